// File: rtl/data_pack_pkg.sv
// Shared widths and FSM state type for the 7-bit to 32-bit symbol packer.
package data_pack_pkg;

    localparam int unsigned SYM_W  = 7;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned FILL_W = $clog2(WORD_W + SYM_W);
    localparam int unsigned ACC_W  = WORD_W + SYM_W - 1;

    localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] SYM_BITS  = FILL_W'(SYM_W);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/data_pack_if.sv
// Symbol-in / word-out handshake bundle of data_pack.
interface data_pack_if;
    import data_pack_pkg::*;

    logic              valid_in;
    logic [SYM_W-1:0]  data_in;
    logic              sop_in;
    logic              eop_in;
    logic              ready_out;
    logic              valid_out;
    logic [WORD_W-1:0] data_out;
    logic              sop_out;
    logic              eop_out;
    logic [FILL_W-1:0] bits_out;
    logic              ready_in;
    logic              err_out;

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, ready_in,
        output ready_out, valid_out, data_out, sop_out, eop_out, bits_out, err_out
    );

    modport master (
        output valid_in, data_in, sop_in, eop_in, ready_in,
        input  ready_out, valid_out, data_out, sop_out, eop_out, bits_out, err_out
    );

endinterface

// File: rtl/data_pack_accum.sv
// Accumulator write/shift datapath: appends one symbol above the current fill.
module pack_accum
    import data_pack_pkg::*;
(
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [FILL_W-1:0] i_fill,
    input  logic [SYM_W-1:0]  i_data,
    input  logic              i_restart,
    output logic [ACC_W-1:0]  o_acc,
    output logic [FILL_W-1:0] o_nf,
    output logic [WORD_W-1:0] o_low,
    output logic [ACC_W-1:0]  o_shift
);

    logic [ACC_W-1:0]  w_base;
    logic [FILL_W-1:0] w_bfill;

    // Bits above fill are always zero, so OR-ing the shifted symbol is a write.
    always_comb begin
        w_base  = i_restart ? '0 : i_acc;
        w_bfill = i_restart ? '0 : i_fill;
        o_acc   = w_base | (ACC_W'(i_data) << w_bfill);
        o_nf    = w_bfill + SYM_BITS;
    end

    assign o_low   = o_acc[WORD_W-1:0];
    assign o_shift = o_acc >> WORD_W;

endmodule

// File: rtl/data_pack.sv
// Packs 7-bit symbols into 32-bit words with sop/eop framing and backpressure.
module data_pack
    import data_pack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    data_pack_if.slave  bus
);

    state_t            r_state, w_state_nxt;
    logic [ACC_W-1:0]  r_acc, w_acc_nxt;
    logic [FILL_W-1:0] r_fill, w_fill_nxt;
    logic              r_sop_pend, w_sop_pend_nxt;
    logic              r_rdy_en;
    logic              r_valid, w_valid_nxt;
    logic [WORD_W-1:0] r_data, w_data_nxt;
    logic              r_sop, w_sop_nxt;
    logic              r_eop, w_eop_nxt;
    logic [FILL_W-1:0] r_bits, w_bits_nxt;
    logic              r_err, w_err_nxt;

    logic              w_slot_free, w_ready, w_accept, w_pend;
    logic [ACC_W-1:0]  w_wr_acc, w_shift;
    logic [FILL_W-1:0] w_nf;
    logic [WORD_W-1:0] w_low;

    assign w_slot_free = !r_valid || bus.ready_in;
    assign w_ready     = r_rdy_en && (r_state == RUN) && w_slot_free;
    assign w_accept    = bus.valid_in && w_ready;
    assign w_pend      = bus.sop_in || r_sop_pend;

    pack_accum u_accum (
        .i_acc     (r_acc),
        .i_fill    (r_fill),
        .i_data    (bus.data_in),
        .i_restart (bus.sop_in),
        .o_acc     (w_wr_acc),
        .o_nf      (w_nf),
        .o_low     (w_low),
        .o_shift   (w_shift)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_fill_nxt     = r_fill;
        w_sop_pend_nxt = r_sop_pend;
        w_valid_nxt    = r_valid && !bus.ready_in;
        w_data_nxt     = r_data;
        w_sop_nxt      = r_sop;
        w_eop_nxt      = r_eop;
        w_bits_nxt     = r_bits;
        w_err_nxt      = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_accept) begin
                    w_err_nxt      = bus.sop_in && (r_fill != '0);
                    w_sop_pend_nxt = w_pend;
                    w_acc_nxt      = w_wr_acc;
                    w_fill_nxt     = w_nf;
                    if (w_nf >= WORD_BITS) begin
                        w_valid_nxt    = 1'b1;
                        w_data_nxt     = w_low;
                        w_sop_nxt      = w_pend;
                        w_eop_nxt      = 1'b0;
                        w_bits_nxt     = WORD_BITS;
                        w_sop_pend_nxt = 1'b0;
                        w_acc_nxt      = w_shift;
                        w_fill_nxt     = w_nf - WORD_BITS;
                        if (bus.eop_in) begin
                            if (w_nf == WORD_BITS) begin
                                w_eop_nxt  = 1'b1;
                                w_acc_nxt  = '0;
                                w_fill_nxt = '0;
                            end else begin
                                w_state_nxt = FLUSH;
                            end
                        end
                    end else if (bus.eop_in) begin
                        w_valid_nxt    = 1'b1;
                        w_data_nxt     = w_low;
                        w_sop_nxt      = w_pend;
                        w_eop_nxt      = 1'b1;
                        w_bits_nxt     = w_nf;
                        w_sop_pend_nxt = 1'b0;
                        w_acc_nxt      = '0;
                        w_fill_nxt     = '0;
                    end
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = r_acc[WORD_W-1:0];
                    w_sop_nxt   = 1'b0;
                    w_eop_nxt   = 1'b1;
                    w_bits_nxt  = r_fill;
                    w_acc_nxt   = '0;
                    w_fill_nxt  = '0;
                    w_state_nxt = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_fill     <= '0;
            r_sop_pend <= 1'b0;
            r_rdy_en   <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_bits     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_acc      <= w_acc_nxt;
            r_fill     <= w_fill_nxt;
            r_sop_pend <= w_sop_pend_nxt;
            r_rdy_en   <= 1'b1;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_sop      <= w_sop_nxt;
            r_eop      <= w_eop_nxt;
            r_bits     <= w_bits_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.ready_out = w_ready;
    assign bus.valid_out = r_valid;
    assign bus.data_out  = r_data;
    assign bus.sop_out   = r_sop;
    assign bus.eop_out   = r_eop;
    assign bus.bits_out  = r_bits;
    assign bus.err_out   = r_err;

endmodule

// File: tb/tb_data_pack.sv
// Directed plus randomized bench for data_pack against a bit-queue packing model.
module tb_data_pack;
    import data_pack_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [5:0]  bits;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_pack_if bus();

    data_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned words_seen = 0;

    bit    bq[$];
    word_t expq[$];
    logic  pend = 1'b0;
    logic  err_due = 1'b0;
    logic  val_due = 1'b0;
    logic  last_acc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream-level model: symbols become bits in a queue, words are cut 32 bits at a time.
    task automatic model_accept(input logic [6:0] d, input logic s, input logic e);
        word_t w;
        int unsigned n;
        logic produced;
        produced = 1'b0;
        if (s) begin
            err_due = (bq.size() != 0);
            bq.delete();
            pend = 1'b1;
        end
        for (int i = 0; i < 7; i++) bq.push_back(d[i]);
        if (bq.size() >= 32) begin
            w.data = '0;
            for (int i = 0; i < 32; i++) w.data[i] = bq.pop_front();
            w.sop = pend;
            pend  = 1'b0;
            w.eop = e && (bq.size() == 0);
            w.bits = 6'd32;
            expq.push_back(w);
            produced = 1'b1;
        end
        if (e && bq.size() != 0) begin
            n = bq.size();
            w.data = '0;
            for (int i = 0; i < int'(n); i++) w.data[i] = bq.pop_front();
            w.sop = pend;
            pend  = 1'b0;
            w.eop = 1'b1;
            w.bits = 6'(n);
            expq.push_back(w);
            produced = 1'b1;
        end
        val_due = produced;
    endtask

    task automatic tick();
        logic sa, wa;
        word_t w;
        @(negedge clk);
        chk("err_out", bus.err_out, err_due);
        if (val_due) chk("word_latency", bus.valid_out, 1'b1);
        err_due = 1'b0;
        val_due = 1'b0;
        sa = bus.valid_in && bus.ready_out;
        wa = bus.valid_out && bus.ready_in;
        if (wa) begin
            words_seen++;
            chk("word_expected", expq.size() != 0, 1'b1);
            if (expq.size() != 0) begin
                w = expq.pop_front();
                chk("data_out", bus.data_out, w.data);
                chk("sop_out", bus.sop_out, w.sop);
                chk("eop_out", bus.eop_out, w.eop);
                chk("bits_out", bus.bits_out, w.bits);
            end
        end
        if (sa) model_accept(bus.data_in, bus.sop_in, bus.eop_in);
        last_acc = sa;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] d, input logic s, input logic e);
        int unsigned k;
        k = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.sop_in   = s;
        bus.eop_in   = e;
        do begin
            tick();
            k++;
        end while (!last_acc && k < 200);
        chk("send_timeout", last_acc, 1'b1);
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        while (expq.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        chk("drain_empty", expq.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, bus.valid_out, 1'b0);
        chk({tag, "_data"},  bus.data_out, 32'h0);
        chk({tag, "_sop"},   bus.sop_out, 1'b0);
        chk({tag, "_eop"},   bus.eop_out, 1'b0);
        chk({tag, "_bits"},  bus.bits_out, 6'd0);
        chk({tag, "_err"},   bus.err_out, 1'b0);
        chk({tag, "_ready"}, bus.ready_out, 1'b0);
    endtask

    initial begin
        logic [31:0] held;
        int unsigned w0, acc_cnt, cyc;

        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
        bus.ready_in = 1'b1;

        #1 rst = 1'b0;
        #2 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        #1 chk("ready_at_release", bus.ready_out, 1'b0);
        @(posedge clk);
        #1 chk("ready_after_release", bus.ready_out, 1'b1);

        // Single-symbol packet.
        send(7'h55, 1'b1, 1'b1);
        chk("t1_valid", bus.valid_out, 1'b1);
        chk("t1_data", bus.data_out, 32'h0000_0055);
        chk("t1_sop", bus.sop_out, 1'b1);
        chk("t1_eop", bus.eop_out, 1'b1);
        chk("t1_bits", bus.bits_out, 6'd7);
        idle(2);

        // 35-bit packet: full word then a 3-bit flush word.
        send(7'h7F, 1'b1, 1'b0);
        repeat (3) send(7'h7F, 1'b0, 1'b0);
        send(7'h7F, 1'b0, 1'b1);
        chk("t2_full_data", bus.data_out, 32'hFFFF_FFFF);
        chk("t2_full_sop", bus.sop_out, 1'b1);
        chk("t2_full_eop", bus.eop_out, 1'b0);
        chk("t2_flush_ready", bus.ready_out, 1'b0);
        tick();
        chk("t2_flush_data", bus.data_out, 32'h0000_0007);
        chk("t2_flush_eop", bus.eop_out, 1'b1);
        chk("t2_flush_bits", bus.bits_out, 6'd3);
        chk("t2_flush_sop", bus.sop_out, 1'b0);
        idle(2);

        // 32 symbols end exactly on a word boundary.
        w0 = words_seen;
        for (int i = 0; i < 32; i++)
            send(7'($urandom), i == 0, i == 31);
        chk("t3_last_eop", bus.eop_out, 1'b1);
        chk("t3_last_bits", bus.bits_out, 6'd32);
        chk("t3_no_flush", bus.ready_out, 1'b1);
        idle(2);
        chk("t3_word_count", words_seen - w0, 7);

        // Downstream backpressure for 10 cycles.
        bus.ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send(7'($urandom), i == 0, 1'b0);
        held = bus.data_out;
        bus.valid_in = 1'b1;
        bus.data_in  = 7'h2A;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_data", bus.data_out, held);
            chk("t4_hold_valid", bus.valid_out, 1'b1);
            chk("t4_hold_ready", bus.ready_out, 1'b0);
        end
        bus.ready_in = 1'b1;
        send(7'h2A, 1'b0, 1'b0);
        send(7'h13, 1'b0, 1'b1);
        idle(3);

        // Unterminated packet then a fresh sop.
        for (int i = 0; i < 3; i++) send(7'($urandom), i == 0, 1'b0);
        send(7'h31, 1'b1, 1'b1);
        chk("t5_err_pulse", bus.err_out, 1'b1);
        chk("t5_data", bus.data_out, 32'h0000_0031);
        chk("t5_sop", bus.sop_out, 1'b1);
        chk("t5_bits", bus.bits_out, 6'd7);
        tick();
        chk("t5_err_single", bus.err_out, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of a stalled packet.
        bus.ready_in = 1'b0;
        for (int i = 0; i < 5; i++) send(7'($urandom), i == 0, 1'b0);
        bus.valid_in = 1'b1;
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        bq.delete();
        expq.delete();
        pend = 1'b0;
        err_due = 1'b0;
        val_due = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 10000 && cyc < 80000) begin
            bus.valid_in = ($urandom_range(0, 3) != 0);
            bus.data_in  = 7'($urandom);
            bus.sop_in   = ($urandom_range(0, 7) == 0);
            bus.eop_in   = ($urandom_range(0, 7) == 0);
            bus.ready_in = ($urandom_range(0, 4) != 0);
            tick();
            cyc++;
            if (last_acc) acc_cnt++;
        end
        chk("random_accepts", acc_cnt, 10000);
        bus.sop_in = 1'b0;
        bus.eop_in = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
